// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample/frame geometry and DAC link FSM states.
package audio_pkg;

    localparam int SYS_CLK_HZ  = 12_000_000;
    localparam int SAMPLE_W    = 10;
    localparam int DAC_FRAME_W = 16;
    localparam int DAC_PAD_HI  = 4;
    localparam int DAC_PAD_LO  = 2;

    localparam logic [SAMPLE_W-1:0] MIDSCALE = 10'h1FF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } dac_state_e;

    function automatic logic [DAC_FRAME_W-1:0] dac_frame(
        input logic [SAMPLE_W-1:0] s
    );
        return {{DAC_PAD_HI{1'b0}}, s, {DAC_PAD_LO{1'b0}}};
    endfunction

endpackage

// File: rtl/tone_dac_spi_tick_gen.sv
// Modulo-DIV free-running counter; tick is high on the cycle it wraps to 0.
module tick_gen #(
    parameter int unsigned DIV = 250
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tone_dac_spi.sv
// Serialises 10-bit tone samples into 16-bit frames for an external SPI DAC.
module tone_dac_spi
    import audio_pkg::*;
#(
    parameter int unsigned         CLK_DIV    = 2,
    parameter int unsigned         SAMPLE_DIV = 250,
    parameter logic [SAMPLE_W-1:0] MUTE_CODE  = MIDSCALE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                mute,
    output logic                dac_cs_n,
    output logic                dac_sclk,
    output logic                dac_din,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun
);

    localparam int unsigned HC_W = $clog2(2 * CLK_DIV);
    localparam logic [HC_W-1:0] HALF_LAST = HC_W'(CLK_DIV - 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(2 * CLK_DIV - 1);
    localparam logic [4:0]      LAST_BIT  = 5'(DAC_FRAME_W);

    logic tick;

    dac_state_e             state_q, state_d;
    logic [HC_W-1:0]        hc_q, hc_d;
    logic [4:0]             bc_q, bc_d;
    logic [DAC_FRAME_W-1:0] shreg_q, shreg_d;
    logic                   cs_n_q, cs_n_d;
    logic                   sclk_q, sclk_d;
    logic                   ovr_q, ovr_d;

    tick_gen #(
        .DIV (SAMPLE_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // din is the shift register MSB; the 2 trailing pad zeros leave it 0 after the frame
    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        bc_d    = bc_q;
        shreg_d = shreg_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        ovr_d   = ovr_q;

        if (tick && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    shreg_d = dac_frame(mute ? MUTE_CODE : sample_in);
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    hc_d    = '0;
                    bc_d    = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (hc_q == HALF_LAST) begin
                    hc_d    = '0;
                    state_d = ST_SHIFT;
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (hc_q == HALF_LAST) begin
                    hc_d    = '0;
                    sclk_d  = ~sclk_q;
                    if (!sclk_q) begin
                        bc_d = bc_q + 1'b1;
                    end else begin
                        shreg_d = shreg_q << 1;
                        if (bc_q == LAST_BIT) begin
                            cs_n_d  = 1'b1;
                            state_d = ST_HOLD;
                        end
                    end
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (hc_q == HOLD_LAST) begin
                    hc_d    = '0;
                    state_d = ST_IDLE;
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hc_q    <= '0;
            bc_q    <= '0;
            shreg_q <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            bc_q    <= bc_d;
            shreg_q <= shreg_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dac_cs_n   = cs_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_din    = shreg_q[DAC_FRAME_W-1];
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_HOLD) && (hc_q == HOLD_LAST);
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_tone_dac_spi.sv
// Scoreboard bench: three DUT configurations, frames decoded off the SPI pins.
module tb_tone_dac_spi;

    typedef struct {
        int          inst;
        logic [15:0] bits;
        int          start;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_n;
    logic [2:0] mute;
    logic [2:0] cs_n;
    logic [2:0] sclk;
    logic [2:0] din;
    logic [2:0] busy;
    logic [2:0] fd;
    logic [2:0] ov;
    logic [9:0] smp [3];

    int cyc   = 0;
    int nrun  = 0;
    int nfail = 0;
    exp_t sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    tone_dac_spi u_a (
        .clk (clk), .rst_n (rst_n[0]), .sample_in (smp[0]), .mute (mute[0]),
        .dac_cs_n (cs_n[0]), .dac_sclk (sclk[0]), .dac_din (din[0]),
        .busy (busy[0]), .frame_done (fd[0]), .overrun (ov[0])
    );

    tone_dac_spi #(.CLK_DIV (2), .SAMPLE_DIV (60)) u_b (
        .clk (clk), .rst_n (rst_n[1]), .sample_in (smp[1]), .mute (mute[1]),
        .dac_cs_n (cs_n[1]), .dac_sclk (sclk[1]), .dac_din (din[1]),
        .busy (busy[1]), .frame_done (fd[1]), .overrun (ov[1])
    );

    tone_dac_spi #(.CLK_DIV (1), .SAMPLE_DIV (40)) u_c (
        .clk (clk), .rst_n (rst_n[2]), .sample_in (smp[2]), .mute (mute[2]),
        .dac_cs_n (cs_n[2]), .dac_sclk (sclk[2]), .dac_din (din[2]),
        .busy (busy[2]), .frame_done (fd[2]), .overrun (ov[2])
    );

    task automatic chk(input string nm, input int got, input int want);
        nrun++;
        if (got != want) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
        end
    endtask

    function automatic int find(input int i);
        foreach (sb[k]) if (sb[k].inst == i) return k;
        return -1;
    endfunction

    task automatic push(input int i, input logic [15:0] b, input int st);
        exp_t e;
        e.inst  = i;
        e.bits  = b;
        e.start = st;
        sb.push_back(e);
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    int          cd    [3] = '{2, 2, 1};
    int          fst   [3] = '{0, 0, 0};
    int          nb    [3] = '{0, 0, 0};
    logic [15:0] bits  [3];
    bit          infr  [3] = '{0, 0, 0};
    bit          pcs   [3] = '{1, 1, 1};
    bit          psclk [3] = '{0, 0, 0};
    bit          pbusy [3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n[i]) begin
                infr[i]  = 0;
                pcs[i]   = 1;
                psclk[i] = 0;
                pbusy[i] = 0;
            end else begin
                if (pcs[i] && !cs_n[i]) begin
                    int k;
                    infr[i] = 1;
                    fst[i]  = cyc;
                    nb[i]   = 0;
                    bits[i] = '0;
                    k = find(i);
                    if (k >= 0)
                        chk($sformatf("u%0d_cs_fall_cycle", i), cyc, sb[k].start);
                end
                if (infr[i] && !psclk[i] && sclk[i] && !cs_n[i]) begin
                    bits[i] = {bits[i][14:0], din[i]};
                    nb[i]++;
                    if (nb[i] == 1)
                        chk($sformatf("u%0d_first_rise", i), cyc - fst[i], 2 * cd[i]);
                end
                if (infr[i] && !pcs[i] && cs_n[i]) begin
                    int k;
                    infr[i] = 0;
                    k = find(i);
                    if (k < 0) begin
                        chk($sformatf("u%0d_unexpected_frame", i), 1, 0);
                    end else begin
                        chk($sformatf("u%0d_frame_bits", i), bits[i], sb[k].bits);
                        chk($sformatf("u%0d_rise_count", i), nb[i], 16);
                        chk($sformatf("u%0d_cs_rise", i), cyc - sb[k].start, 33 * cd[i]);
                        sb.delete(k);
                    end
                end
                if (fd[i])
                    chk($sformatf("u%0d_frame_done_at", i), cyc - fst[i], 35 * cd[i] - 1);
                if (pbusy[i] && !busy[i])
                    chk($sformatf("u%0d_busy_fall_at", i), cyc - fst[i], 35 * cd[i]);
                pcs[i]   = cs_n[i];
                psclk[i] = sclk[i];
                pbusy[i] = busy[i];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel;
        int rel2;
        rst_n = 3'b000;
        mute  = 3'b000;
        smp[0] = 10'h3FF;
        smp[1] = 10'h3C1;
        smp[2] = 10'h0AB;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n[0], 1);
        chk("rst_sclk", sclk[0], 0);
        chk("rst_din", din[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_frame_done", fd[0], 0);
        chk("rst_overrun", ov[0], 0);

        rel = cyc;
        push(0, 16'h0FFC, rel + 250);
        push(1, 16'h0F04, rel + 60);
        push(1, 16'h0004, rel + 180);
        push(2, 16'h02AC, rel + 40);
        rst_n = 3'b111;

        wait_to(rel + 70);
        smp[1] = 10'h001;
        wait_to(rel + 78);
        rst_n[2] = 1'b0;
        wait_to(rel + 119);
        chk("u1_overrun_before", ov[1], 0);
        wait_to(rel + 120);
        chk("u1_busy_at_tick", busy[1], 1);
        chk("u1_overrun_set", ov[1], 1);
        wait_to(rel + 245);
        chk("u1_overrun_sticky", ov[1], 1);
        wait_to(rel + 255);
        rst_n[1] = 1'b0;

        wait_to(rel + 400);
        mute[0] = 1'b1;
        smp[0]  = 10'h2AA;
        push(0, 16'h07FC, rel + 500);

        wait_to(rel + 600);
        mute[0] = 1'b0;
        smp[0]  = 10'h155;
        push(0, 16'h0554, rel + 750);
        wait_to(rel + 770);
        smp[0]  = 10'h000;
        mute[0] = 1'b1;

        wait_to(rel + 850);
        mute[0] = 1'b0;
        smp[0]  = 10'h3FF;
        wait_to(rel + 1021);
        chk("u0_sclk_high_pre_reset", sclk[0], 1);
        rst_n[0] = 1'b0;
        #1;
        chk("u0_midrst_cs_n", cs_n[0], 1);
        chk("u0_midrst_sclk", sclk[0], 0);
        chk("u0_midrst_busy", busy[0], 0);
        chk("u0_midrst_din", din[0], 0);

        repeat (3) @(negedge clk);
        rel2 = cyc;
        smp[0] = 10'h2C3;
        push(0, 16'h0B0C, rel2 + 250);
        rst_n[0] = 1'b1;

        wait_to(rel2 + 330);
        chk("sb_left_over", sb.size(), 0);
        chk("u0_no_overrun", ov[0], 0);
        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule
